matmul_sequencer: RTL and testbench



---
 rtl/matmul_seq_pkg.sv | 17 +
 rtl/iact_skew_buffer.sv | 49 ++++
 rtl/matmul_sequencer.sv | 142 ++++++++++++++
 tb/tb_matmul_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/matmul_seq_pkg.sv
// Shared types and helpers for the systolic-array control sequencer.
package matmul_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_WT,
      STREAM,
      DRAIN,
      DONE
   } seq_state_t;

   // Bit offset of a lane's element inside a flattened row bus.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/iact_skew_buffer.sv
// Diagonal skew for activation lanes: lane r is delayed by r cycles, data and valid together.
module iact_skew_buffer
   import matmul_seq_pkg::*;
#(
   parameter int ROWS      = 4,
   parameter int WORD_SIZE = 16
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      in_valid,
   input  logic [ROWS*WORD_SIZE-1:0] in_data,
   output logic [ROWS-1:0]           out_valid,
   output logic [ROWS*WORD_SIZE-1:0] out_data
);

   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      localparam int LSB = lane_lsb(r, WORD_SIZE);
      logic [WORD_SIZE-1:0] lane_in;

      // Gate data at the input so idle lanes always present zero.
      assign lane_in = in_valid ? in_data[LSB +: WORD_SIZE] : '0;

      if (r == 0) begin : g_pass
         assign out_valid[r]                 = in_valid;
         assign out_data[LSB +: WORD_SIZE]   = lane_in;
      end else begin : g_dly
         logic [r-1:0]                vld_pipe;
         logic [r-1:0][WORD_SIZE-1:0] dat_pipe;

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               vld_pipe <= '0;
               dat_pipe <= '0;
            end else begin
               vld_pipe[0] <= in_valid;
               dat_pipe[0] <= lane_in;
               for (int i = 1; i < r; i++) begin
                  vld_pipe[i] <= vld_pipe[i-1];
                  dat_pipe[i] <= dat_pipe[i-1];
               end
            end
         end

         assign out_valid[r]               = vld_pipe[r-1];
         assign out_data[LSB +: WORD_SIZE] = dat_pipe[r-1];
      end
   end

endmodule

// File: rtl/matmul_sequencer.sv
// Weight-stationary systolic array sequencer: load weights, stream skewed activations,
// capture result rows into the oact BRAM, then report done/error.
module matmul_sequencer
   import matmul_seq_pkg::*;
#(
   parameter int ROWS             = 4,
   parameter int WORD_SIZE        = 16,
   parameter int INPUT_ADDR_WIDTH = 2,
   parameter int DRAIN_TIMEOUT    = 16
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        start_matmul,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic                        wt_we,
   output logic [INPUT_ADDR_WIDTH-1:0] wt_addr,
   input  logic [ROWS*WORD_SIZE-1:0]   wt_dout,
   output logic                        iact_we,
   output logic [INPUT_ADDR_WIDTH-1:0] iact_addr,
   input  logic [ROWS*WORD_SIZE-1:0]   iact_dout,
   output logic                        oact_we,
   output logic [INPUT_ADDR_WIDTH-1:0] oact_addr,
   output logic [ROWS*WORD_SIZE-1:0]   oact_din,
   output logic                        sa_wt_load,
   output logic [INPUT_ADDR_WIDTH-1:0] sa_wt_row,
   output logic [ROWS*WORD_SIZE-1:0]   sa_wt_data,
   output logic [ROWS-1:0]             sa_iact_valid,
   output logic [ROWS*WORD_SIZE-1:0]   sa_iact_data,
   input  logic                        sa_out_valid,
   input  logic [ROWS*WORD_SIZE-1:0]   sa_out_data
);

   localparam int AW  = INPUT_ADDR_WIDTH;
   localparam int DW  = ROWS * WORD_SIZE;
   localparam int CW  = $clog2(2 * ROWS) + 1;
   localparam int OCW = $clog2(ROWS + 1);
   localparam int IW  = $clog2(DRAIN_TIMEOUT + 1);

   seq_state_t      state, nxt;
   logic [CW-1:0]   cyc;
   logic [OCW-1:0]  out_cnt;
   logic [IW-1:0]   idle_cnt;
   logic            err_q, set_err, accept, timeout, start_ok, stream_vld;
   logic            cap_vld;
   logic [AW-1:0]   cap_addr;
   logic [DW-1:0]   cap_data;

   assign start_ok = (state == IDLE) && start_matmul;
   assign accept   = sa_out_valid && ((state == STREAM) || (state == DRAIN))
                     && (out_cnt < OCW'(ROWS));
   assign timeout  = !sa_out_valid && (idle_cnt == IW'(DRAIN_TIMEOUT - 1));

   always_comb begin
      nxt     = state;
      set_err = 1'b0;
      case (state)
         IDLE:    if (start_matmul) nxt = LOAD_WT;
         LOAD_WT: if (cyc == CW'(ROWS)) nxt = STREAM;
         STREAM:  if (cyc == CW'(2 * ROWS - 1)) nxt = DRAIN;
         DRAIN: begin
            if (out_cnt == OCW'(ROWS)) begin
               nxt = DONE;
            end else if (timeout) begin
               nxt     = DONE;
               set_err = 1'b1;
            end
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         cyc      <= '0;
         out_cnt  <= '0;
         idle_cnt <= '0;
         err_q    <= 1'b0;
         cap_vld  <= 1'b0;
         cap_addr <= '0;
         cap_data <= '0;
      end else begin
         state <= nxt;
         // Phase counter restarts on every state change.
         if ((nxt != state) || !((state == LOAD_WT) || (state == STREAM)))
            cyc <= '0;
         else
            cyc <= cyc + CW'(1);

         if (start_ok)    out_cnt <= '0;
         else if (accept) out_cnt <= out_cnt + OCW'(1);

         if (state != DRAIN)    idle_cnt <= '0;
         else if (sa_out_valid) idle_cnt <= '0;
         else                   idle_cnt <= idle_cnt + IW'(1);

         if (start_ok)     err_q <= 1'b0;
         else if (set_err) err_q <= 1'b1;

         cap_vld <= accept;
         if (accept) begin
            cap_addr <= AW'(out_cnt);
            cap_data <= sa_out_data;
         end
      end
   end

   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign error   = err_q;
   assign wt_we   = 1'b0;
   assign iact_we = 1'b0;

   // BRAM read data lags the address by one cycle, so row k lands in phase cycle k+1.
   assign wt_addr    = ((state == LOAD_WT) && (cyc < CW'(ROWS))) ? AW'(cyc) : '0;
   assign sa_wt_load = (state == LOAD_WT) && (cyc != '0);
   assign sa_wt_row  = sa_wt_load ? AW'(cyc - CW'(1)) : '0;
   assign sa_wt_data = sa_wt_load ? wt_dout : '0;

   assign iact_addr  = ((state == STREAM) && (cyc < CW'(ROWS))) ? AW'(cyc) : '0;
   assign stream_vld = (state == STREAM) && (cyc != '0) && (cyc <= CW'(ROWS));

   assign oact_we   = cap_vld;
   assign oact_addr = cap_vld ? cap_addr : '0;
   assign oact_din  = cap_vld ? cap_data : '0;

   iact_skew_buffer #(
      .ROWS      (ROWS),
      .WORD_SIZE (WORD_SIZE)
   ) u_skew (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (stream_vld),
      .in_data   (iact_dout),
      .out_valid (sa_iact_valid),
      .out_data  (sa_iact_data)
   );

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer (ROWS=4): per-cycle expectations derived from
// the start-relative timeline; cycle label L is sampled on the falling edge.
module tb_matmul_sequencer;

   localparam int ROWS = 4;
   localparam int WS   = 16;
   localparam int AW   = 2;
   localparam int DT   = 16;
   localparam int DW   = ROWS * WS;

   logic          clk = 1'b0;
   logic          resetn = 1'b1;
   logic          start_matmul = 1'b0;
   logic          busy, done, error, wt_we, iact_we, oact_we, sa_wt_load;
   logic [AW-1:0] wt_addr, iact_addr, oact_addr, sa_wt_row;
   logic [DW-1:0] wt_dout = '0;
   logic [DW-1:0] iact_dout = '0;
   logic [DW-1:0] oact_din, sa_wt_data, sa_iact_data;
   logic [ROWS-1:0] sa_iact_valid;
   logic          sa_out_valid = 1'b0;
   logic [DW-1:0] sa_out_data = '0;

   int n_checks = 0;
   int n_errors = 0;
   int wr_cnt   = 0;
   int wr_base;
   int beat_lab [5];

   matmul_sequencer #(
      .ROWS(ROWS), .WORD_SIZE(WS), .INPUT_ADDR_WIDTH(AW), .DRAIN_TIMEOUT(DT)
   ) dut (
      .clk(clk), .resetn(resetn), .start_matmul(start_matmul),
      .busy(busy), .done(done), .error(error),
      .wt_we(wt_we), .wt_addr(wt_addr), .wt_dout(wt_dout),
      .iact_we(iact_we), .iact_addr(iact_addr), .iact_dout(iact_dout),
      .oact_we(oact_we), .oact_addr(oact_addr), .oact_din(oact_din),
      .sa_wt_load(sa_wt_load), .sa_wt_row(sa_wt_row), .sa_wt_data(sa_wt_data),
      .sa_iact_valid(sa_iact_valid), .sa_iact_data(sa_iact_data),
      .sa_out_valid(sa_out_valid), .sa_out_data(sa_out_data)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [63:0] wt_val(input int k);
      return 64'h1000_2000_3000_4000 + 64'(k) * 64'h0001_0001_0001_0001;
   endfunction

   // Activation element (row k, lane r) = 16*k + r.
   function automatic logic [63:0] iact_val(input int k);
      logic [63:0] v;
      v = '0;
      for (int r = 0; r < ROWS; r++) v[r*WS +: WS] = 16'(16 * k + r);
      return v;
   endfunction

   function automatic logic [63:0] res_row(input int i);
      return {16'hD000 + 16'(i), 16'hC000 + 16'(i), 16'hB000 + 16'(i), 16'hA000 + 16'(i)};
   endfunction

   // BRAM models (1-cycle read latency) and oact write counter.
   always @(posedge clk) begin
      wt_dout   <= wt_val(int'(wt_addr));
      iact_dout <= iact_val(int'(iact_addr));
      if (oact_we) wr_cnt <= wr_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, " ctl"}, 64'({busy, done, error, wt_we, iact_we, oact_we, sa_wt_load,
                              sa_iact_valid, wt_addr, iact_addr, oact_addr, sa_wt_row}), 64'd0);
      chk({tag, " data"}, oact_din | sa_wt_data | sa_iact_data, 64'd0);
   endtask

   task automatic do_start();
      start_matmul = 1'b1;
      @(negedge clk);
      start_matmul = 1'b0;
   endtask

   // Runs labels 1..last after an accepted start; beats from beat_lab drive sa_out_valid.
   task automatic run_seq(input string nm, input int done_lab, input logic exp_err,
                          input int start2_lab, input int stop_lab);
      int last, k;
      logic bv, ewe;
      logic [63:0] bd, ed, edin, ewd;
      logic [3:0] ev;
      last = (stop_lab > 0) ? stop_lab - 1 : done_lab + 3;
      for (int L = 1; L <= last; L++) begin
         bv = 1'b0; bd = '0;
         for (int i = 0; i < 5; i++)
            if (beat_lab[i] == L) begin bv = 1'b1; bd = res_row(i); end
         sa_out_valid = bv;
         sa_out_data  = bd;
         start_matmul = (L == start2_lab);

         ev = '0; ed = '0;
         for (int r = 0; r < ROWS; r++) begin
            k = L - 7 - r;
            if (k >= 0 && k < ROWS) begin ev[r] = 1'b1; ed[r*WS +: WS] = 16'(16 * k + r); end
         end
         ewe = 1'b0; edin = '0; ewd = '0;
         for (int i = 0; i < ROWS; i++)
            if (beat_lab[i] > 0 && beat_lab[i] + 1 == L) begin
               ewe = 1'b1; ewd = 64'(i); edin = res_row(i);
            end

         chk($sformatf("%s busy L%0d", nm, L), 64'(busy), 64'(L <= done_lab));
         chk($sformatf("%s done L%0d", nm, L), 64'(done), 64'(L == done_lab));
         chk($sformatf("%s error L%0d", nm, L), 64'(error), 64'(exp_err && L >= done_lab));
         chk($sformatf("%s wt_addr L%0d", nm, L), 64'(wt_addr),
             (L >= 1 && L <= 4) ? 64'(L - 1) : 64'd0);
         chk($sformatf("%s wt_load L%0d", nm, L), 64'({sa_wt_load, sa_wt_row}),
             (L >= 2 && L <= 5) ? 64'({1'b1, 2'(L - 2)}) : 64'd0);
         chk($sformatf("%s wt_data L%0d", nm, L), sa_wt_data,
             (L >= 2 && L <= 5) ? wt_val(L - 2) : 64'd0);
         chk($sformatf("%s iact_addr L%0d", nm, L), 64'(iact_addr),
             (L >= 6 && L <= 9) ? 64'(L - 6) : 64'd0);
         chk($sformatf("%s iact_valid L%0d", nm, L), 64'(sa_iact_valid), 64'(ev));
         chk($sformatf("%s iact_data L%0d", nm, L), sa_iact_data, ed);
         chk($sformatf("%s oact_we L%0d", nm, L), 64'(oact_we), 64'(ewe));
         chk($sformatf("%s oact_addr L%0d", nm, L), 64'(oact_addr), ewd);
         chk($sformatf("%s oact_din L%0d", nm, L), oact_din, edin);
         @(negedge clk);
      end
      sa_out_valid = 1'b0;
      sa_out_data  = '0;
      start_matmul = 1'b0;
   endtask

   initial begin
      // Reset with start low: everything stays zero, valid beats in IDLE ignored.
      #2 resetn = 1'b0;
      #1 chk_quiet("reset_async");
      repeat (3) @(negedge clk);
      chk_quiet("reset_held");
      resetn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sa_out_valid = i[0];
         sa_out_data  = 64'hDEAD_BEEF_0000_0000 | 64'(i);
         @(negedge clk);
         chk_quiet($sformatf("idle%0d", i));
      end
      sa_out_valid = 1'b0;
      sa_out_data  = '0;
      chk("idle_writes", 64'(wr_cnt), 64'd0);

      // Full run, rows returned back to back in STREAM: done at T+15.
      beat_lab = '{10, 11, 12, 13, -1};
      wr_base = wr_cnt;
      do_start();
      run_seq("full", 15, 1'b0, -1, 0);
      chk("full nwr", 64'(wr_cnt - wr_base), 64'd4);

      // Two rows only; row 1 arrives in DRAIN (T+17) and restarts the idle count.
      beat_lab = '{10, 17, -1, -1, -1};
      wr_base = wr_cnt;
      do_start();
      run_seq("tmo", 17 + DT + 1, 1'b1, -1, 0);
      chk("tmo nwr", 64'(wr_cnt - wr_base), 64'd2);

      // Restart clears error; a start mid-STREAM and a fifth beat are both ignored.
      beat_lab = '{10, 11, 12, 13, 14};
      wr_base = wr_cnt;
      do_start();
      run_seq("dup", 15, 1'b0, 8, 0);
      chk("dup nwr", 64'(wr_cnt - wr_base), 64'd4);

      // Reset in DRAIN after one row has been written.
      beat_lab = '{10, -1, -1, -1, -1};
      wr_base = wr_cnt;
      do_start();
      run_seq("abort", 100, 1'b0, -1, 16);
      resetn = 1'b0;
      #1 chk_quiet("abort_now");
      chk("abort nwr", 64'(wr_cnt - wr_base), 64'd1);
      sa_out_valid = 1'b1;
      sa_out_data  = res_row(1);
      repeat (2) @(negedge clk);
      chk_quiet("abort_held");
      sa_out_valid = 1'b0;
      sa_out_data  = '0;
      resetn = 1'b1;
      repeat (4) @(negedge clk);
      chk_quiet("abort_after");
      chk("abort nwr_after", 64'(wr_cnt - wr_base), 64'd1);

      // Clean sequence after the abort.
      beat_lab = '{10, 11, 12, 13, -1};
      wr_base = wr_cnt;
      do_start();
      run_seq("rerun", 15, 1'b0, -1, 0);
      chk("rerun nwr", 64'(wr_cnt - wr_base), 64'd4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
